instr_fetch_unit: RTL

- Sequential fetch stage directly upstream of the main decoder in the MIPS datapath.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents instr/opcode to decode.
- Computes the next PC from sequential/branch outcome once the datapath retires the current instruction.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/next_pc_calc.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS datapath slice around the fetch stage.
//   WORD_W        : datapath word width in bits
//   OP_*          : primary opcode values (instr[31:26]) that the front end cares about
//   fetch_state_t : state encoding of the instruction fetch FSM
//   branch_offset : converts a 16-bit branch immediate into a byte offset
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_HALT  = 6'd63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  // Branch immediates count words, so the sign-extended value is shifted
  // left by two to form a byte offset relative to pc + 4.
  function automatic logic [WORD_W-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc       in  32  address of the instruction being retired
//   instr    in  32  instruction being retired
//   branch   in  1   decoder Branch for instr
//   zero     in  1   ALU zero flag for instr
//   pc_plus4 out 32  pc + 4
//   next_pc  out 32  address of the instruction to fetch after instr
// Build option:
//   IFU_JUMP_EN  when defined, opcode j redirects to the pseudo-direct jump target
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] instr,
  input  logic              branch,
  input  logic              zero,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] branch_target;
  logic              take_branch;

  // All additions are modulo 2^32; running off the top of the address space
  // simply wraps, matching what the rest of the datapath expects.
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + branch_offset(instr[15:0]);
  assign take_branch   = branch & zero;

`ifdef IFU_JUMP_EN
  logic [WORD_W-1:0] jump_target;
  logic              is_jump;

  // Pseudo-direct jump: keep the upper nibble of pc + 4 and splice in the
  // 26-bit word index. A jump wins over any branch/zero indication.
  assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign is_jump     = (instr[31:26] == OP_J);

  always_comb begin
    next_pc = pc_plus4;
    if (is_jump) begin
      next_pc = jump_target;
    end else if (take_branch) begin
      next_pc = branch_target;
    end
  end
`else
  // Without jump support the opcode and upper immediate bits play no part
  // in the next-PC decision; they are folded here only to mark them as
  // intentionally unused.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:16];

  always_comb begin
    next_pc = pc_plus4;
    if (take_branch) begin
      next_pc = branch_target;
    end
  end
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage feeding the main decoder. Holds the PC, fetches one word at a
// time over a req/ack handshake, keeps it in the instruction register until
// the datapath retires it, then moves the PC to the sequential or branch
// successor.
// Parameters:
//   RESET_PC     PC loaded on reset (word aligned)
//   HALT_OPCODE  opcode that stops fetching for good (until reset)
// Ports:
//   clk          in  1   system clock, rising edge
//   reset        in  1   asynchronous active-high reset
//   imem_req     out 1   fetch request to instruction memory
//   imem_addr    out 32  byte address of requested word (= pc)
//   imem_ack     in  1   memory accepted request, imem_rdata valid this cycle
//   imem_rdata   in  32  fetched instruction word
//   instr        out 32  instruction register
//   opcode       out 6   instr[31:26] for the decoder
//   pc           out 32  address of instr
//   pc_plus4     out 32  pc + 4
//   instr_valid  out 1   instr is live and waiting to be retired
//   retire       in  1   datapath finished instr this cycle
//   branch       in  1   decoder Branch for instr
//   zero         in  1   ALU zero flag for instr
//   halted       out 1   halt opcode fetched, fetch stopped
// Build option:
//   IFU_JUMP_EN  enables j handling inside next_pc_calc
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]        HALT_OPCODE = OP_HALT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              instr_valid,
  input  logic              retire,
  input  logic              branch,
  input  logic              zero,
  output logic              halted
);

  fetch_state_t      state;
  logic [WORD_W-1:0] next_pc;

  // The successor address is always computed from the registered pc/instr,
  // so it is stable for the whole EXEC state and only branch/zero at the
  // retire cycle decide which successor is taken.
  next_pc_calc u_next_pc_calc (
    .pc       (pc),
    .instr    (instr),
    .branch   (branch),
    .zero     (zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // The request address is the pc itself; pc only changes on retire, so the
  // address cannot move while a request is outstanding.
  assign imem_addr = pc;
  assign opcode    = instr[31:26];

  // Fetch FSM with registered handshake/status outputs. Each output is
  // updated on the same edge as the state transition that implies it, so
  // imem_req, instr_valid and halted always line up with the state:
  //   IDLE -> REQ  : one settling cycle after reset, then start fetching
  //   REQ  -> EXEC : ack captures the word; instr_valid next cycle
  //   REQ  -> HALT : ack with the halt opcode stops fetching permanently
  //   EXEC -> REQ  : retire commits next_pc and requests it next cycle
  // ack outside REQ and retire outside EXEC fall through untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            if (imem_rdata[31:26] == HALT_OPCODE) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state       <= EXEC;
              instr_valid <= 1'b1;
            end
          end
        end

        EXEC: begin
          if (retire) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end

        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
